fetch_stage: RTL and testbench

- Instruction-fetch front end feeding the decode/datapath stage.
- Owns the PC register and drives a synchronous instruction RAM with 1-cycle read latency.
- Presents {valid, pc, pc+4, instr} to decode and absorbs decode back-pressure with a one-entry hold buffer.
- Takes branch/jump redirects from later stages and squashes the wrong-path instruction.

---
 rtl/mips_pkg.sv | 15 +
 rtl/fetch_skid.sv | 42 ++++
 rtl/fetch_stage.sv | 146 ++++++++++++++
 tb/tb_fetch_stage.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared fetch-side constants and helpers.
// Imported by fetch_stage and fetch_skid.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP    = 32'h0000_0000;
  localparam int          WORD_LSB     = 2;

  function automatic logic [31:0] word_align(
    input logic [31:0] addr
  );
    return {addr[31:WORD_LSB], {WORD_LSB{1'b0}}};
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry hold buffer for the returned instruction word.
// clear wins over capture; reset empties it.
module fetch_skid
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        capture,
  input  logic        clear,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        valid
);

  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d = 1'b1;
      data_d  = din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= INSTR_NOP;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign dout  = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, sync IMEM read, skid, redirects.
// Optional misaligned-redirect trap via FETCH_ALIGN_CHK_EN.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          IMEM_AW  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
`ifdef FETCH_ALIGN_CHK_EN
  output logic               if_adel,
  output logic [31:0]        if_badvaddr,
`endif
  output logic               id_valid,
  output logic [31:0]        id_pc,
  output logic [31:0]        id_pcplus4,
  output logic [31:0]        id_instr
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        req_valid_q, req_valid_d;
  logic [31:0] fetch_addr;
  logic [31:0] redir_pc;
  logic        hold_valid;
  logic [31:0] hold_instr;
  logic        skid_capture, skid_clear;
  logic        do_rst, do_redir, do_stall;
  logic        redir_bad, fetch_idle;

`ifdef FETCH_ALIGN_CHK_EN
  logic        adel_q, adel_d;
  logic [31:0] badv_q, badv_d;

  assign redir_bad   = |redirect_pc[1:0];
  assign fetch_idle  = adel_q;
  assign if_adel     = adel_q;
  assign if_badvaddr = badv_q;
`else
  assign redir_bad   = 1'b0;
  assign fetch_idle  = 1'b0;
`endif

  assign redir_pc = word_align(redirect_pc);
  assign do_rst   = rst;
  assign do_redir = !rst && redirect_valid;
  assign do_stall = !rst && !redirect_valid && stall;

  always_comb begin
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    req_valid_d  = req_valid_q;
    fetch_addr   = pc_q;
    imem_en      = 1'b0;
    skid_capture = 1'b0;
    skid_clear   = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
    adel_d       = adel_q;
    badv_d       = badv_q;
`endif
    unique case (1'b1)
      do_rst: begin
        skid_clear = 1'b1;
      end
      do_redir: begin
        skid_clear = 1'b1;
        if (redir_bad) begin
          req_valid_d = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
          adel_d      = 1'b1;
          badv_d      = redirect_pc;
`endif
        end else begin
          imem_en     = 1'b1;
          fetch_addr  = redir_pc;
          req_pc_d    = redir_pc;
          req_valid_d = 1'b1;
          pc_d        = redir_pc + 32'd4;
`ifdef FETCH_ALIGN_CHK_EN
          adel_d      = 1'b0;
`endif
        end
      end
      do_stall: begin
        skid_capture = req_valid_q && !hold_valid;
      end
      default: begin
        skid_clear = 1'b1;
        if (fetch_idle) begin
          req_valid_d = 1'b0;
        end else begin
          imem_en     = 1'b1;
          req_pc_d    = pc_q;
          req_valid_d = 1'b1;
          pc_d        = pc_q + 32'd4;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      req_pc_q    <= RESET_PC;
      req_valid_q <= 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
      adel_q      <= 1'b0;
      badv_q      <= 32'h0;
`endif
    end else begin
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      req_valid_q <= req_valid_d;
`ifdef FETCH_ALIGN_CHK_EN
      adel_q      <= adel_d;
      badv_q      <= badv_d;
`endif
    end
  end

  fetch_skid u_skid (
    .clk     (clk),
    .rst     (rst),
    .capture (skid_capture),
    .clear   (skid_clear),
    .din     (imem_rdata),
    .dout    (hold_instr),
    .valid   (hold_valid)
  );

  // Full-width shift keeps upper PC bits read; addr just truncates.
  assign imem_addr  = IMEM_AW'(fetch_addr >> WORD_LSB);
  assign id_valid   = (req_valid_q || hold_valid)
                    && !redirect_valid && !rst;
  assign id_instr   = hold_valid ? hold_instr : imem_rdata;
  assign id_pc      = req_pc_q;
  assign id_pcplus4 = req_pc_q + 32'd4;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage (RESET_PC 0 and FFFF_FFF8).
// Define FETCH_ALIGN_CHK_EN to also exercise the alignment trap.
module tb_fetch_stage;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst1, stall, redir;
  logic [31:0] rpc;
  logic        tie0 = 1'b0;
  logic [31:0] tie32 = 32'h0;

  logic        en0, en1, v0, v1;
  logic [9:0]  addr0, addr1;
  logic [31:0] rd0, rd1;
  logic [31:0] pc0, pc1, p40, p41, in0, in1;
`ifdef FETCH_ALIGN_CHK_EN
  logic        adel0, adel1;
  logic [31:0] bad0, bad1;
`endif

  logic [31:0] mem [1024];
  exp_t q0[$];
  exp_t q1[$];
  int checks = 0;
  int errors = 0;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | i;
    mem[0] = 32'h11; mem[1] = 32'h22;
    mem[2] = 32'h33; mem[3] = 32'h44;
  end

  // RAM returns junk when the previous cycle had no read.
  always_ff @(posedge clk) begin
    rd0 <= en0 ? mem[addr0] : 32'hDEAD_BEEF;
    rd1 <= en1 ? mem[addr1] : 32'hDEAD_BEEF;
  end

  fetch_stage #(.RESET_PC(32'h0), .IMEM_AW(10)) u0 (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redir), .redirect_pc(rpc),
    .imem_en(en0), .imem_addr(addr0), .imem_rdata(rd0),
`ifdef FETCH_ALIGN_CHK_EN
    .if_adel(adel0), .if_badvaddr(bad0),
`endif
    .id_valid(v0), .id_pc(pc0),
    .id_pcplus4(p40), .id_instr(in0)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .IMEM_AW(10)) u1 (
    .clk(clk), .rst(rst1), .stall(tie0),
    .redirect_valid(tie0), .redirect_pc(tie32),
    .imem_en(en1), .imem_addr(addr1), .imem_rdata(rd1),
`ifdef FETCH_ALIGN_CHK_EN
    .if_adel(adel1), .if_badvaddr(bad1),
`endif
    .id_valid(v1), .id_pc(pc1),
    .id_pcplus4(p41), .id_instr(in1)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic [31:0] pc,
                              input logic [31:0] instr);
    exp_t e;
    e.pc = pc;
    e.instr = instr;
    return e;
  endfunction

  // Peek while stalled (output must hold), pop when consumed.
  always @(negedge clk) begin
    if (v0) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL u0 unexpected instr pc=%h", pc0);
      end else begin
        exp_t e;
        e = stall ? q0[0] : q0.pop_front();
        chk("u0 id_pc", pc0, e.pc);
        chk("u0 id_pcplus4", p40, e.pc + 32'd4);
        chk("u0 id_instr", in0, e.instr);
      end
    end
  end

  always @(negedge clk) begin
    if (v1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL u1 unexpected instr pc=%h", pc1);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("u1 id_pc", pc1, e.pc);
        chk("u1 id_pcplus4", p41, e.pc + 32'd4);
        chk("u1 id_instr", in1, e.instr);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rst1 = 1'b1;
    stall = 1'b0; redir = 1'b0; rpc = 32'h0;
    q0.push_back(mk(32'h0, 32'h11));
    q0.push_back(mk(32'h4, 32'h22));
    q0.push_back(mk(32'h8, 32'h33));
    q0.push_back(mk(32'h40, 32'hC0DE_0010));
    q0.push_back(mk(32'h44, 32'hC0DE_0011));
    q0.push_back(mk(32'h80, 32'hC0DE_0020));
    q0.push_back(mk(32'h84, 32'hC0DE_0021));
    q0.push_back(mk(32'h88, 32'hC0DE_0022));
    q0.push_back(mk(32'h0, 32'h11));
    q0.push_back(mk(32'h4, 32'h22));
    q1.push_back(mk(32'hFFFF_FFF8, 32'hC0DE_03FE));
    q1.push_back(mk(32'hFFFF_FFFC, 32'hC0DE_03FF));
    q1.push_back(mk(32'h0000_0000, 32'h11));

    tick(); tick(); #2;
    chk("rst id_valid", 32'(v0), 32'h0);
    chk("rst imem_en", 32'(en0), 32'h0);
    chk("rst id_pc", pc0, 32'h0);
    chk("rst u1 id_pc", pc1, 32'hFFFF_FFF8);

    tick(); rst = 1'b0; rst1 = 1'b0; #2;
    chk("c0 addr", 32'(addr0), 32'h0);
    chk("c0 id_valid", 32'(v0), 32'h0);
    chk("c0 u1 addr", 32'(addr1), 32'h3FE);
    tick(); #2;
    chk("c1 addr", 32'(addr0), 32'h1);
    chk("c1 u1 addr", 32'(addr1), 32'h3FF);
    tick(); stall = 1'b1; #2;
    chk("stall en 0", 32'(en0), 32'h0);
    chk("wrap u1 addr", 32'(addr1), 32'h0);
    tick(); #2;
    chk("stall en 1", 32'(en0), 32'h0);
    tick(); rst1 = 1'b1; #2;
    chk("stall en 2", 32'(en0), 32'h0);
    tick(); stall = 1'b0; #2;
    chk("release addr", 32'(addr0), 32'h2);
    tick();

    tick(); redir = 1'b1; rpc = 32'h40; #2;
    chk("redir id_valid", 32'(v0), 32'h0);
    chk("redir imem_en", 32'(en0), 32'h1);
    chk("redir addr", 32'(addr0), 32'h10);
    tick(); redir = 1'b0;
    tick(); stall = 1'b1;

    tick(); redir = 1'b1;
`ifdef FETCH_ALIGN_CHK_EN
    rpc = 32'h80;
`else
    rpc = 32'h81;
`endif
    void'(q0.pop_front());
    #2;
    chk("redir+stall en", 32'(en0), 32'h1);
    chk("redir+stall addr", 32'(addr0), 32'h20);
    chk("redir+stall valid", 32'(v0), 32'h0);
    tick(); stall = 1'b0; redir = 1'b0;
    tick();

    tick(); stall = 1'b1;
    tick(); rst = 1'b1; void'(q0.pop_front()); #2;
    chk("rst stall valid", 32'(v0), 32'h0);
    chk("rst stall en", 32'(en0), 32'h0);
    tick(); rst = 1'b0; stall = 1'b0; #2;
    chk("refetch addr", 32'(addr0), 32'h0);
    chk("refetch valid", 32'(v0), 32'h0);
    tick(); tick();

`ifdef FETCH_ALIGN_CHK_EN
    q0.push_back(mk(32'h80, 32'hC0DE_0020));
    tick(); redir = 1'b1; rpc = 32'h42; #2;
    chk("adel en", 32'(en0), 32'h0);
    tick(); redir = 1'b0; #2;
    chk("adel set", 32'(adel0), 32'h1);
    chk("adel badv", bad0, 32'h42);
    chk("adel idle valid", 32'(v0), 32'h0);
    chk("adel idle en", 32'(en0), 32'h0);
    tick(); #2;
    chk("adel idle valid2", 32'(v0), 32'h0);
    tick(); redir = 1'b1; rpc = 32'h80; #2;
    chk("adel resume addr", 32'(addr0), 32'h20);
    chk("adel resume en", 32'(en0), 32'h1);
    tick(); redir = 1'b0; #2;
    chk("adel cleared", 32'(adel0), 32'h0);
`endif

    tick(); #2;
    chk("q0 drained", 32'(q0.size()), 32'h0);
    chk("q1 drained", 32'(q1.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
